// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C controller among NUM_REQ requesters.
// The winner's command is latched at grant and held until its done pulse.
module i2c_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 64,
  parameter int XFER_TIMEOUT  = 20000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          i2c_rw,
  output logic [ADDR_WIDTH-1:0]         i2c_addr,
  output logic [DATA_WIDTH-1:0]         i2c_tx_data,
  output logic                          i2c_ready,
  input  logic                          i2c_busy,
  input  logic [DATA_WIDTH-1:0]         i2c_rx_data,
  input  logic                          i2c_valid,
  input  logic                          i2c_ack_error
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int CNTW = $clog2(TMAX + 1);
  localparam logic [CNTW-1:0] START_LAST = CNTW'(START_TIMEOUT - 1);
  localparam logic [CNTW-1:0] XFER_LAST  = CNTW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_END, RESPOND} state_e;

  state_e                  state_q;
  logic [IDXW-1:0]         last_q, owner_q, win_d, rr_idx;
  logic [CNTW-1:0]         cnt_q;
  logic [NUM_REQ-1:0]      gnt_q, done_q;
  logic                    err_q, ready_q, rw_q;
  logic [DATA_WIDTH-1:0]   rdata_q, txd_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    found;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // First requester found scanning upward from the one after the last owner.
  always_comb begin
    win_d  = last_q;
    rr_idx = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = IDXW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[rr_idx]) begin
        win_d = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDXW'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      txd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|req) begin
            owner_q        <= win_d;
            gnt_q          <= '0;
            gnt_q[win_d]   <= 1'b1;
            rw_q           <= req_rw[win_d];
            addr_q         <= addr_v[win_d];
            txd_q          <= wdata_v[win_d];
            err_q          <= 1'b0;
            rdata_q        <= '0;
            ready_q        <= 1'b1;
            state_q        <= LAUNCH;
          end
        end
        LAUNCH: begin
          ready_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (i2c_busy) begin
            cnt_q   <= '0;
            state_q <= WAIT_END;
          end else if (cnt_q == START_LAST) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            cnt_q   <= '0;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_END: begin
          // Status is captured even on the cycle busy drops.
          if (i2c_valid)     rdata_q <= i2c_rx_data;
          if (i2c_ack_error) err_q   <= 1'b1;
          if (!i2c_busy) begin
            done_q  <= gnt_q;
            cnt_q   <= '0;
            state_q <= RESPOND;
          end else if (cnt_q == XFER_LAST) begin
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            cnt_q   <= '0;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESPOND: begin
          done_q  <= '0;
          gnt_q   <= '0;
          last_q  <= owner_q;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign i2c_rw      = rw_q;
  assign i2c_addr    = addr_q;
  assign i2c_tx_data = txd_q;
  assign i2c_ready   = ready_q;
endmodule
